// File: rtl/cond_pkg.sv
// rtl/cond_pkg.sv - shared state encoding and default parameters for the input conditioner
`timescale 1ns/1ps

package cond_pkg;

    typedef enum logic [1:0] {
        S_LOW      = 2'd0,
        S_CHK_HIGH = 2'd1,
        S_HIGH     = 2'd2,
        S_CHK_LOW  = 2'd3
    } state_t;

    localparam int DEF_SYNC_STAGES = 2;
    localparam int DEF_DB_CYCLES   = 4;
    localparam int DEF_EVT_W       = 8;

endpackage

// File: rtl/sync_chain.sv
// rtl/sync_chain.sv - parameterised flop chain bringing an asynchronous input into the clk domain
`timescale 1ns/1ps

module sync_chain #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] ff;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ff <= '0;
        end else begin
            ff <= {ff[STAGES-2:0], d};
        end
    end

    assign q = ff[STAGES-1];

endmodule

// File: rtl/input_conditioner.sv
// rtl/input_conditioner.sv - synchronise, debounce and edge-detect one raw input; COND_EVENT_COUNT_EN adds evt_cnt
`timescale 1ns/1ps

module input_conditioner
    import cond_pkg::*;
#(
    parameter int SYNC_STAGES = DEF_SYNC_STAGES,
    parameter int DB_CYCLES   = DEF_DB_CYCLES
`ifdef COND_EVENT_COUNT_EN
    ,
    parameter int EVT_W       = DEF_EVT_W
`endif
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall,
    output logic busy
`ifdef COND_EVENT_COUNT_EN
    ,
    output logic [EVT_W-1:0] evt_cnt
`endif
);

    localparam int             CNT_W    = $clog2(DB_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             sq;

    sync_chain #(
        .STAGES(SYNC_STAGES)
    ) u_sync (
        .clk(clk),
        .rst(rst),
        .d  (din),
        .q  (sq)
    );

    // The candidate level must be seen on DB_CYCLES consecutive enabled edges
    // after the edge that opened the check; any disagreement drops back.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= S_LOW;
            cnt     <= '0;
            level   <= 1'b0;
            rise    <= 1'b0;
            fall    <= 1'b0;
`ifdef COND_EVENT_COUNT_EN
            evt_cnt <= '0;
`endif
        end else begin
            rise <= 1'b0;
            fall <= 1'b0;
            if (en) begin
                case (state)
                    S_LOW: begin
                        if (sq) begin
                            state <= S_CHK_HIGH;
                            cnt   <= '0;
                        end
                    end
                    S_CHK_HIGH: begin
                        if (!sq) begin
                            state <= S_LOW;
                        end else if (cnt == CNT_LAST) begin
                            state <= S_HIGH;
                            level <= 1'b1;
                            rise  <= 1'b1;
`ifdef COND_EVENT_COUNT_EN
                            evt_cnt <= evt_cnt + 1'b1;
`endif
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    S_HIGH: begin
                        if (!sq) begin
                            state <= S_CHK_LOW;
                            cnt   <= '0;
                        end
                    end
                    S_CHK_LOW: begin
                        if (sq) begin
                            state <= S_HIGH;
                        end else if (cnt == CNT_LAST) begin
                            state <= S_LOW;
                            level <= 1'b0;
                            fall  <= 1'b1;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    default: state <= S_LOW;
                endcase
            end
        end
    end

    assign busy = (state == S_CHK_HIGH) || (state == S_CHK_LOW);

endmodule

// File: tb/tb_input_conditioner.sv
// tb/tb_input_conditioner.sv - randomized and directed checks of input_conditioner against a run-length model
`timescale 1ns/1ps

module tb_input_conditioner;

    localparam int SYNC = 2;
    localparam int DB   = 4;
`ifdef COND_EVENT_COUNT_EN
    localparam int EW   = 2;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic en  = 1'b1;
    logic din = 1'b0;
    logic level, rise, fall, busy;
`ifdef COND_EVENT_COUNT_EN
    logic [EW-1:0] evt_cnt;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    input_conditioner #(
        .SYNC_STAGES(SYNC),
        .DB_CYCLES  (DB)
`ifdef COND_EVENT_COUNT_EN
        ,
        .EVT_W      (EW)
`endif
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .en   (en),
        .din  (din),
        .level(level),
        .rise (rise),
        .fall (fall),
        .busy (busy)
`ifdef COND_EVENT_COUNT_EN
        ,
        .evt_cnt(evt_cnt)
`endif
    );

    // Reference: the input seen by the debouncer is din delayed SYNC edges;
    // the level flips once it has disagreed with the level on DB+1
    // consecutive enabled edges. Disabled edges neither count nor break a run.
    bit dly [SYNC];
    int run     = 0;
    bit m_level = 0;
    bit m_rise  = 0;
    bit m_fall  = 0;
    int m_evt   = 0;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < SYNC; i++) dly[i] = 1'b0;
            run = 0; m_level = 0; m_rise = 0; m_fall = 0; m_evt = 0;
        end else begin
            bit seen;
            seen = dly[SYNC-1];
            for (int i = SYNC-1; i > 0; i--) dly[i] = dly[i-1];
            dly[0] = din;
            m_rise = 0;
            m_fall = 0;
            if (en) begin
                if (seen != m_level) begin
                    run++;
                    if (run == DB + 1) begin
                        run = 0;
                        m_level = seen;
                        if (seen) begin
                            m_rise = 1;
`ifdef COND_EVENT_COUNT_EN
                            m_evt = (m_evt + 1) % (1 << EW);
`endif
                        end else begin
                            m_fall = 1;
                        end
                    end
                end else begin
                    run = 0;
                end
            end
        end
    end

    function automatic logic [3:0] model_vec();
        return {m_level, m_rise, m_fall, run != 0};
    endfunction

    task automatic test_reset();
        rst = 1'b0;
        din = 1'b1;
        en  = 1'b1;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            n_cmp++;
            if ({level, rise, fall, busy} !== 4'b0000) begin
                n_bad++;
                $display("FAIL reset_hold cyc %0d: got %b want 0000", k, {level, rise, fall, busy});
            end
        end
        rst = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            n_cmp++;
            if (level !== (k >= 6) || rise !== (k == 6)) begin
                n_bad++;
                $display("FAIL reset_release edge %0d: level/rise got %b%b want %b%b",
                         k, level, rise, k >= 6, k == 6);
            end
            n_cmp++;
            if ({level, rise, fall, busy} !== model_vec()) begin
                n_bad++;
                $display("FAIL reset_model edge %0d: got %b want %b", k, {level, rise, fall, busy}, model_vec());
            end
        end
        din = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            n_cmp++;
            if ({level, rise, fall, busy} !== model_vec()) begin
                n_bad++;
                $display("FAIL reset_drain cyc %0d: got %b want %b", k, {level, rise, fall, busy}, model_vec());
            end
        end
    endtask

    task automatic test_glitch();
        bit saw_busy = 0;
        bit saw_rise = 0;
        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            n_cmp++;
            if ({level, rise, fall, busy} !== model_vec()) begin
                n_bad++;
                $display("FAIL glitch cyc %0d: got %b want %b", i, {level, rise, fall, busy}, model_vec());
            end
            if (busy === 1'b1) saw_busy = 1;
            if (rise !== 1'b0 || level !== 1'b0) saw_rise = 1;
            din = (i < 3);
        end
        n_cmp++;
        if (!saw_busy || saw_rise || busy !== 1'b0) begin
            n_bad++;
            $display("FAIL glitch_summary: busy_seen=%0d rise_or_level=%0d busy_end=%b want 1 0 0",
                     saw_busy, saw_rise, busy);
        end
    endtask

    task automatic test_press_release();
        int rises   = 0;
        int falls   = 0;
        int fall_at = -1;
        for (int i = 0; i < 35; i++) begin
            @(negedge clk);
            n_cmp++;
            if ({level, rise, fall, busy} !== model_vec()) begin
                n_bad++;
                $display("FAIL press cyc %0d: got %b want %b", i, {level, rise, fall, busy}, model_vec());
            end
            if (rise === 1'b1) rises++;
            if (fall === 1'b1) begin
                falls++;
                fall_at = i;
            end
            if (i == 19) begin
                n_cmp++;
                if (level !== 1'b1) begin
                    n_bad++;
                    $display("FAIL press_level_high: got %b want 1", level);
                end
            end
            din = (i < 20);
        end
        n_cmp++;
        if (rises != 1 || falls != 1 || fall_at != 27 || level !== 1'b0) begin
            n_bad++;
            $display("FAIL press_summary: rises=%0d falls=%0d fall_at=%0d level=%b want 1 1 27 0",
                     rises, falls, fall_at, level);
        end
    endtask

    task automatic test_en_gating();
        int rise_at = -1;
        bit gated_pulse = 0;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            n_cmp++;
            if ({level, rise, fall, busy} !== model_vec()) begin
                n_bad++;
                $display("FAIL en_gate cyc %0d: got %b want %b", i, {level, rise, fall, busy}, model_vec());
            end
            if (rise === 1'b1 && rise_at < 0) rise_at = i;
            if (i >= 4 && i <= 8 && (rise === 1'b1 || fall === 1'b1)) gated_pulse = 1;
            din = 1'b1;
            en  = !(i >= 3 && i <= 7);
        end
        n_cmp++;
        if (rise_at != 12 || gated_pulse) begin
            n_bad++;
            $display("FAIL en_gate_summary: rise_at=%0d gated_pulse=%0d want 12 0", rise_at, gated_pulse);
        end
        din = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            n_cmp++;
            if ({level, rise, fall, busy} !== model_vec()) begin
                n_bad++;
                $display("FAIL en_drain cyc %0d: got %b want %b", i, {level, rise, fall, busy}, model_vec());
            end
        end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            n_cmp++;
            if ({level, rise, fall, busy} !== model_vec()) begin
                n_bad++;
                $display("FAIL rst_mid_pre cyc %0d: got %b want %b", i, {level, rise, fall, busy}, model_vec());
            end
            din = 1'b1;
        end
        n_cmp++;
        if (busy !== 1'b1) begin
            n_bad++;
            $display("FAIL rst_mid_busy_before: got %b want 1", busy);
        end
        #2 rst = 1'b0;
        #1;
        n_cmp++;
        if (busy !== 1'b0 || level !== 1'b0) begin
            n_bad++;
            $display("FAIL rst_mid_async: busy=%b level=%b want 0 0", busy, level);
        end
        @(negedge clk);
        rst = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            n_cmp++;
            if (rise !== (k == 6) || {level, rise, fall, busy} !== model_vec()) begin
                n_bad++;
                $display("FAIL rst_mid_requal edge %0d: got %b want %b", k, {level, rise, fall, busy}, model_vec());
            end
        end
        din = 1'b0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            n_cmp++;
            if ({level, rise, fall, busy} !== model_vec()) begin
                n_bad++;
                $display("FAIL rst_mid_drain cyc %0d: got %b want %b", k, {level, rise, fall, busy}, model_vec());
            end
        end
    endtask

    task automatic test_random();
        int left = 0;
        for (int i = 0; i < 420; i++) begin
            @(negedge clk);
            n_cmp++;
            if ({level, rise, fall, busy} !== model_vec()) begin
                n_bad++;
                $display("FAIL random cyc %0d: got %b want %b", i, {level, rise, fall, busy}, model_vec());
            end
            n_cmp++;
            if (rise === 1'b1 && fall === 1'b1) begin
                n_bad++;
                $display("FAIL random_exclusive cyc %0d: rise=1 fall=1 want not both", i);
            end
            if (i < 400) begin
                if (left == 0) begin
                    din  = ~din;
                    left = $urandom_range(1, 9);
                end
                left--;
                en = ($urandom_range(0, 7) != 0);
            end else begin
                din = 1'b0;
                en  = 1'b1;
            end
        end
    endtask

`ifdef COND_EVENT_COUNT_EN
    task automatic test_event_count();
        int exp_seq [5] = '{1, 2, 3, 0, 1};
        int idx = 0;
        @(negedge clk);
        rst = 1'b0;
        din = 1'b0;
        en  = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (evt_cnt !== '0) begin
            n_bad++;
            $display("FAIL evt_reset: got %0d want 0", evt_cnt);
        end
        rst = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            n_cmp++;
            if (evt_cnt !== EW'(m_evt) || {level, rise, fall, busy} !== model_vec()) begin
                n_bad++;
                $display("FAIL evt_model cyc %0d: evt %0d want %0d, out %b want %b",
                         i, evt_cnt, m_evt, {level, rise, fall, busy}, model_vec());
            end
            if (rise === 1'b1 && idx < 5) begin
                n_cmp++;
                if (evt_cnt !== EW'(exp_seq[idx])) begin
                    n_bad++;
                    $display("FAIL evt_seq press %0d: got %0d want %0d", idx, evt_cnt, exp_seq[idx]);
                end
                idx++;
            end
            din = ((i % 20) < 10);
        end
        n_cmp++;
        if (idx != 5) begin
            n_bad++;
            $display("FAIL evt_press_count: got %0d want 5", idx);
        end
    endtask
`endif

    initial begin
        #1;
        test_reset();
        test_glitch();
        test_press_release();
        test_en_gating();
        test_reset_mid();
        test_random();
`ifdef COND_EVENT_COUNT_EN
        test_event_count();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
